// File: rtl/data_mem_hs_if.sv
// Request/response bundle between the load/store unit and data_mem_hs.
//   master : load/store unit side (drives the request and rsp_ready)
//   slave  : memory side (drives req_ready and the response)
interface data_mem_hs_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [AWIDTH-1:0] req_addr;
  logic [2:0]        req_size;
  logic [DWIDTH-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DWIDTH-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_hs.sv
// Byte-addressed little-endian data memory with a valid/ready request and a
// registered response one cycle after accept.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : request/response bundle (slave side)
//   err_count  : saturating count of faulted requests
// Size code [1:0]: 00 word, 01 half, 10 byte, 11 double. For loads [2]
// selects sign extension (except double); for stores [2]=1 is a fault.
module data_mem_hs #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 256,
  parameter int ECNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  data_mem_hs_if.slave      bus,
  output logic [ECNT_W-1:0] err_count
);
  localparam int NB = DWIDTH / 8;
  localparam int LW = $clog2(DEPTH);

  typedef enum logic {IDLE, RESP} state_t;
  state_t state, state_nxt;

  logic [7:0] mem [DEPTH];

  logic accept;
  assign accept = bus.req_valid && bus.req_ready;

  // ---------------- request decode / fault detection ----------------
  logic [3:0] nbytes;
  logic       misal, dbl, sgn, oor, fault;
  logic [AWIDTH:0] last_byte;

  always_comb begin
    nbytes = 4'd4;
    misal  = 1'b0;
    case (bus.req_size[1:0])
      2'b00:   begin nbytes = 4'd4; misal = bus.req_addr[1:0] != 2'b00; end
      2'b01:   begin nbytes = 4'd2; misal = bus.req_addr[0];            end
      2'b10:   begin nbytes = 4'd1; misal = 1'b0;                       end
      default: begin nbytes = 4'd8; misal = bus.req_addr[2:0] != 3'b000; end
    endcase
  end

  assign dbl       = bus.req_size[1:0] == 2'b11;
  assign sgn       = !bus.req_we && bus.req_size[2] && !dbl;
  // One extra bit so the range check cannot wrap at the top of the address space.
  assign last_byte = {1'b0, bus.req_addr} + (AWIDTH+1)'(nbytes) - (AWIDTH+1)'(1);
  assign oor       = last_byte >= (AWIDTH+1)'(DEPTH);
  assign fault     = misal || (dbl && (DWIDTH == 32)) ||
                     (bus.req_we && bus.req_size[2]) || oor;

  // ---------------- byte lanes ----------------
  logic [NB-1:0][LW-1:0] lane_addr;
  logic [NB-1:0]         lane_en;
  logic [NB-1:0][7:0]    lane_rd;
  logic [NB-1:0][7:0]    lane_mask;

  for (genvar i = 0; i < NB; i++) begin : g_lane
    // Lane address wraps inside the array; a wrapped lane only occurs on a
    // faulted request, which neither writes nor returns data.
    assign lane_addr[i] = bus.req_addr[LW-1:0] + LW'(i);
    assign lane_en[i]   = 4'(i) < nbytes;
    assign lane_rd[i]   = mem[lane_addr[i]];
    assign lane_mask[i] = {8{lane_en[i]}};
  end

  logic [DWIDTH-1:0] raw, mask, ldata;
  logic              sign_bit;

  assign raw  = lane_rd & lane_mask;
  assign mask = lane_mask;

  always_comb begin
    sign_bit = 1'b0;
    case (bus.req_size[1:0])
      2'b10:   sign_bit = raw[7];
      2'b01:   sign_bit = raw[15];
      2'b00:   sign_bit = raw[31];
      default: sign_bit = 1'b0;
    endcase
  end

  // Sign extension fills every bit above the loaded bytes.
  assign ldata = (sgn && sign_bit) ? (raw | ~mask) : raw;

  // Memory array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst_n && accept && bus.req_we && !fault) begin
      for (int i = 0; i < NB; i++) begin
        if (lane_en[i]) mem[lane_addr[i]] <= bus.req_wdata[8*i +: 8];
      end
    end
  end

  // ---------------- response registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      err_count     <= '0;
    end else if (accept) begin
      bus.rsp_rdata <= (fault || bus.req_we) ? '0 : ldata;
      bus.rsp_err   <= fault;
      if (fault && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept)                                state_nxt = RESP;
    else if (state == RESP && bus.rsp_ready)   state_nxt = IDLE;
  end

  always_comb begin
    bus.rsp_valid = state == RESP;
    bus.req_ready = (state == IDLE) || (state == RESP && bus.rsp_ready);
  end
endmodule

// File: tb/tb_data_mem_hs.sv
module tb_data_mem_hs;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] err_count;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_hs_if #(.AWIDTH(32), .DWIDTH(32)) bus();

  data_mem_hs #(.AWIDTH(32), .DWIDTH(32), .DEPTH(256), .ECNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .err_count (err_count)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_cnt;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [31:0] a, input logic [2:0] sz,
                     input logic [31:0] wd, input logic [31:0] er, input logic ee, input int ec);
    vec_t v;
    v.we = we; v.addr = a; v.size = sz; v.wdata = wd;
    v.exp_rdata = er; v.exp_err = ee; v.exp_cnt = ec;
    tv.push_back(v);
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a;
    bus.req_size = sz; bus.req_wdata = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // store/load table, streamed one request per cycle
    add(1, 32'h10, 3'b000, 32'h11223344, 32'h0,        0, 0);
    add(1, 32'h10, 3'b010, 32'hFFFFFFAB, 32'h0,        0, 0);
    add(0, 32'h10, 3'b000, 32'h0,        32'h112233AB, 0, 0);
    add(1, 32'h20, 3'b010, 32'h00000080, 32'h0,        0, 0);
    add(0, 32'h20, 3'b110, 32'h0,        32'hFFFFFF80, 0, 0);
    add(0, 32'h20, 3'b010, 32'h0,        32'h00000080, 0, 0);
    add(1, 32'h22, 3'b001, 32'h00008001, 32'h0,        0, 0);
    add(0, 32'h22, 3'b101, 32'h0,        32'hFFFF8001, 0, 0);
    add(0, 32'h22, 3'b001, 32'h0,        32'h00008001, 0, 0);
    add(0, 32'h10, 3'b100, 32'h0,        32'h112233AB, 0, 0);
    add(0, 32'h13, 3'b000, 32'h0,        32'h0,        1, 1);  // misaligned word
    add(1, 32'h21, 3'b001, 32'h00005555, 32'h0,        1, 2);  // misaligned half store
    add(0, 32'h18, 3'b111, 32'h0,        32'h0,        1, 3);  // double on 32-bit
    add(0, 32'hFE, 3'b000, 32'h0,        32'h0,        1, 4);  // past end (also misaligned)
    add(0, 32'h10, 3'b000, 32'h0,        32'h112233AB, 0, 4);
    add(1, 32'h30, 3'b100, 32'h00000001, 32'h0,        1, 5);  // store with size[2]=1
    add(0, 32'h22, 3'b001, 32'h0,        32'h00008001, 0, 5);  // faulted store left 0x22 alone
    add(1, 32'h40, 3'b000, 32'hDEADBEEF, 32'h0,        0, 5);
    add(0, 32'h40, 3'b000, 32'h0,        32'hDEADBEEF, 0, 5);
    add(1, 32'h44, 3'b001, 32'h1234CAFE, 32'h0,        0, 5);
    add(0, 32'h44, 3'b001, 32'h0,        32'h0000CAFE, 0, 5);
    add(1, 32'h46, 3'b010, 32'h0000007F, 32'h0,        0, 5);
    add(0, 32'h46, 3'b110, 32'h0,        32'h0000007F, 0, 5);
    add(1, 32'hFC, 3'b000, 32'h01020304, 32'h0,        0, 5);
    add(0, 32'hFC, 3'b000, 32'h0,        32'h01020304, 0, 5);  // last legal word
    add(0, 32'hFF, 3'b010, 32'h0,        32'h00000001, 0, 5);  // last legal byte
    add(0, 32'hFF, 3'b001, 32'h0,        32'h0,        1, 6);
    add(0, 32'h100, 3'b010, 32'h0,       32'h0,        1, 7);  // first byte out of range
    add(0, 32'h40, 3'b000, 32'h0,        32'hDEADBEEF, 0, 7);
    add(1, 32'h38, 3'b011, 32'h0,        32'h0,        1, 8);  // double store on 32-bit

    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_size = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset rsp_err",   32'(bus.rsp_err), 32'd0);
    chk("reset err_count", 32'(err_count), 32'd0);
    chk("reset req_ready", 32'(bus.req_ready), 32'd1);
    rst_n = 1'b1;

    // streaming table: check response i-1 while presenting request i
    for (int i = 0; i <= tv.size(); i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("v%0d rsp_valid", i-1), 32'(bus.rsp_valid), 32'd1);
        chk($sformatf("v%0d rsp_rdata", i-1), bus.rsp_rdata, tv[i-1].exp_rdata);
        chk($sformatf("v%0d rsp_err",   i-1), 32'(bus.rsp_err), 32'(tv[i-1].exp_err));
        chk($sformatf("v%0d err_count", i-1), 32'(err_count), 32'(tv[i-1].exp_cnt));
        chk($sformatf("v%0d req_ready", i-1), 32'(bus.req_ready), 32'd1);
      end
      if (i < tv.size()) drive(tv[i].we, tv[i].addr, tv[i].size, tv[i].wdata);
      else               bus.req_valid = 1'b0;
    end

    // backpressure: hold the response three cycles with a competing request waiting
    @(negedge clk);
    chk("idle rsp_valid", 32'(bus.rsp_valid), 32'd0);
    drive(0, 32'h40, 3'b000, 32'h0);
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    drive(0, 32'h20, 3'b010, 32'h0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d rsp_valid", k), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("stall%0d rsp_rdata", k), bus.rsp_rdata, 32'hDEADBEEF);
      chk($sformatf("stall%0d req_ready", k), 32'(bus.req_ready), 32'd0);
      if (k < 2) @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("release req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("after stall rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("after stall rsp_rdata", bus.rsp_rdata, 32'h00000080);
    chk("after stall rsp_err",   32'(bus.rsp_err), 32'd0);
    @(negedge clk);
    chk("drain rsp_valid", 32'(bus.rsp_valid), 32'd0);

    // reset while a response is pending
    drive(0, 32'h10, 3'b000, 32'h0);
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("pre-reset rsp_valid", 32'(bus.rsp_valid), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst-in-resp rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst-in-resp err_count", 32'(err_count), 32'd0);
    chk("rst-in-resp req_ready", 32'(bus.req_ready), 32'd1);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    drive(0, 32'h10, 3'b000, 32'h0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("post-reset load rdata", bus.rsp_rdata, 32'h112233AB);
    chk("post-reset load err",   32'(bus.rsp_err), 32'd0);

    // fault counter saturation
    drive(0, 32'h01, 3'b000, 32'h0);
    repeat (260) @(negedge clk);
    bus.req_valid = 1'b0;
    chk("sat err_count", 32'(err_count), 32'd255);
    chk("sat rsp_err",   32'(bus.rsp_err), 32'd1);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
